// File: rtl/alu_add8.sv
// Registered WIDTH-bit ripple-carry adder slice with carry/overflow/zero/negative flags.
// One-cycle latency; out_valid marks each accepted operand pair.

module alu_add8_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

module alu_add8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             out_valid
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_c;
    logic             carry_c;
    logic             ovf_c;
    logic             zero_c;
    logic             neg_c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        alu_add8_fa u_fa (
            .a  (A[i]),
            .b  (B[i]),
            .ci (c[i]),
            .s  (sum_c[i]),
            .co (c[i+1])
        );
    end

    // Signed overflow from the carry into vs. out of the sign bit.
    assign carry_c = c[WIDTH];
    assign ovf_c   = c[WIDTH] ^ c[WIDTH-1];
    assign zero_c  = ~|sum_c;
    assign neg_c   = sum_c[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            S         <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b1;
            negative  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                S        <= sum_c;
                carry    <= carry_c;
                overflow <= ovf_c;
                zero     <= zero_c;
                negative <= neg_c;
            end
        end
    end

endmodule

// File: tb/tb_alu_add8.sv
// Randomized bench for alu_add8 against an arithmetic reference model.
// Directed cases from the plan run first, then a random stream.

module tb_alu_add8;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] S;
    logic       carry;
    logic       overflow;
    logic       zero;
    logic       negative;
    logic       out_valid;

    int checks = 0;
    int errors = 0;

    int m_s   = 0;
    int m_c   = 0;
    int m_ov  = 0;
    int m_z   = 1;
    int m_n   = 0;
    int m_vld = 0;

    alu_add8 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .S         (S),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int to_signed8(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    task automatic model(input int r, input int v, input int a, input int b);
        int full;
        int ssum;
        if (r != 0) begin
            m_s = 0; m_c = 0; m_ov = 0; m_z = 1; m_n = 0; m_vld = 0;
        end else begin
            m_vld = v;
            if (v != 0) begin
                full = a + b;
                ssum = to_signed8(a) + to_signed8(b);
                m_s  = full % 256;
                m_c  = (full > 255) ? 1 : 0;
                m_ov = (ssum > 127 || ssum < -128) ? 1 : 0;
                m_z  = (m_s == 0) ? 1 : 0;
                m_n  = (m_s >= 128) ? 1 : 0;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".S"}, int'(S), m_s);
        check({tag, ".carry"}, int'(carry), m_c);
        check({tag, ".ovf"}, int'(overflow), m_ov);
        check({tag, ".zero"}, int'(zero), m_z);
        check({tag, ".neg"}, int'(negative), m_n);
        check({tag, ".vld"}, int'(out_valid), m_vld);
    endtask

    task automatic step(input string tag, input int r, input int v,
                        input int a, input int b);
        rst      = r[0];
        in_valid = v[0];
        A        = a[7:0];
        B        = b[7:0];
        model(r, v, a, b);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    initial begin
        int r;
        int v;
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0;

        step("rst0", 1, 0, 0, 0);
        step("rst1", 1, 1, 9, 9);
        check("rst_zero", int'(zero), 1);

        step("basic", 0, 1, 10, 5);
        check("basic_S", int'(S), 15);
        step("basic_hold", 0, 0, 0, 0);
        check("basic_hold_S", int'(S), 15);
        check("basic_hold_vld", int'(out_valid), 0);

        step("uwrap", 0, 1, 255, 1);
        check("uwrap_S", int'(S), 0);
        check("uwrap_c", int'(carry), 1);
        step("uwrap2", 0, 1, 255, 255);
        check("uwrap2_S", int'(S), 254);

        step("sovf", 0, 1, 127, 1);
        check("sovf_S", int'(S), 128);
        check("sovf_ov", int'(overflow), 1);
        step("sovf2", 0, 1, 128, 128);
        check("sovf2_ov", int'(overflow), 1);
        check("sovf2_z", int'(zero), 1);

        step("pipe0", 0, 1, 1, 2);
        check("pipe0_S", int'(S), 3);
        step("pipe1", 0, 1, 3, 4);
        check("pipe1_S", int'(S), 7);
        step("pipe2", 0, 1, 200, 100);
        check("pipe2_S", int'(S), 44);
        check("pipe2_c", int'(carry), 1);
        step("pipe3", 0, 1, 0, 0);
        check("pipe3_z", int'(zero), 1);
        check("pipe3_vld", int'(out_valid), 1);

        step("hold_cap", 0, 1, 20, 22);
        for (int i = 0; i < 5; i++) begin
            step("hold", 0, 0, int'($urandom_range(255)), int'($urandom_range(255)));
            check("hold_S", int'(S), 42);
        end

        step("rprio", 1, 1, 50, 60);
        check("rprio_S", int'(S), 0);
        check("rprio_vld", int'(out_valid), 0);
        step("rprio_after", 0, 1, 50, 60);
        check("rprio_after_S", int'(S), 110);

        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(31) == 0) ? 1 : 0;
            v = ($urandom_range(3) != 0) ? 1 : 0;
            step("rand", r, v, int'($urandom_range(255)), int'($urandom_range(255)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
